i2c_slave_write_receiver: RTL and testbench

Consumes the synchronized and debounced SDA/SCL pair produced by the bus conditioning stage and implements a write-only I2C slave receiver. Detects START/STOP, matches the 7-bit address, shifts in data bytes MSB-first and generates ACKs through an open-drain pull-low request. Delivers each received data byte to downstream logic with a single-cycle valid strobe.

---
 rtl/i2c_slave_write_receiver_if.sv | 38 +++
 rtl/i2c_slave_write_receiver.sv | 160 ++++++++++++++++
 tb/tb_i2c_slave_write_receiver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_write_receiver_if.sv
// Bus bundle between the conditioned I2C pins and the write receiver.
// Latency: none (wires only).
// Backpressure: none; byte_valid is a strobe that downstream must take.
//
// Signals:
//   sda_filtered, scl_filtered : conditioned bus levels (driver -> receiver)
//   sda_pull_low               : open-drain low request (receiver -> pad)
//   received_byte, byte_valid  : delivered data byte and its one-cycle strobe
//   address_matched, busy      : transaction status
interface i2c_slave_write_receiver_if;
  logic       sda_filtered;
  logic       scl_filtered;
  logic       sda_pull_low;
  logic [7:0] received_byte;
  logic       byte_valid;
  logic       address_matched;
  logic       busy;

  modport master (
    output sda_filtered,
    output scl_filtered,
    input  sda_pull_low,
    input  received_byte,
    input  byte_valid,
    input  address_matched,
    input  busy
  );

  modport slave (
    input  sda_filtered,
    input  scl_filtered,
    output sda_pull_low,
    output received_byte,
    output byte_valid,
    output address_matched,
    output busy
  );
endinterface

// File: rtl/i2c_slave_write_receiver.sv
// Write-only I2C slave: START/STOP detect, 7-bit address match, MSB-first data bytes, ACK via SDA pull-low.
// Latency: events act one control_clock after the filtered input changes; byte_valid one cycle after the 8th SCL rise.
// Backpressure: none; each byte is presented for one cycle with byte_valid and held until the next byte.
//
// Ports:
//   control_clock   : system clock shared with the bus conditioning stage
//   control_reset_n : asynchronous active-low reset
//   bus             : slave modport of i2c_slave_write_receiver_if
module i2c_slave_write_receiver #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50
) (
  input  logic                         control_clock,
  input  logic                         control_reset_n,
  i2c_slave_write_receiver_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDRESS,
    ADDRESS_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t     state_q, state_nx;
  logic [3:0] count_q, count_nx;
  logic [7:0] shift_q, shift_nx;
  logic [7:0] rx_byte_q, rx_byte_nx;
  logic       pull_q, pull_nx;
  logic       valid_q, valid_nx;
  logic       matched_q, matched_nx;
  logic       busy_q, busy_nx;
  logic       sda_prev, scl_prev;

  logic start_evt, stop_evt, scl_rise, scl_fall;

  // Bus events are decoded against the previous-cycle levels, so each is
  // visible in the cycle the filtered input changes.
  assign start_evt = scl_prev & bus.scl_filtered & sda_prev & ~bus.sda_filtered;
  assign stop_evt  = scl_prev & bus.scl_filtered & ~sda_prev & bus.sda_filtered;
  assign scl_rise  = ~scl_prev & bus.scl_filtered;
  assign scl_fall  = scl_prev & ~bus.scl_filtered;

  always_comb begin
    state_nx   = state_q;
    count_nx   = count_q;
    shift_nx   = shift_q;
    rx_byte_nx = rx_byte_q;
    pull_nx    = pull_q;
    valid_nx   = 1'b0;
    matched_nx = matched_q;
    busy_nx    = busy_q;

    if (start_evt) begin
      // Repeated START takes exactly the same path as a fresh one.
      state_nx   = ADDRESS;
      count_nx   = 4'd0;
      pull_nx    = 1'b0;
      matched_nx = 1'b0;
      busy_nx    = 1'b1;
    end else if (stop_evt) begin
      state_nx   = IDLE;
      pull_nx    = 1'b0;
      matched_nx = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        ADDRESS: begin
          if (scl_rise) begin
            shift_nx = {shift_q[6:0], bus.sda_filtered};
            if (count_q != 4'd8) count_nx = count_q + 4'd1;
          end else if (scl_fall && count_q == 4'd8) begin
            count_nx = 4'd0;
            if (shift_q[7:1] == SLAVE_ADDRESS && !shift_q[0]) begin
              pull_nx    = 1'b1;
              matched_nx = 1'b1;
              state_nx   = ADDRESS_ACK;
            end else begin
              // Address mismatch or read request: leave SDA released (NACK).
              state_nx = IGNORE;
            end
          end
        end

        ADDRESS_ACK: begin
          if (scl_fall) begin
            pull_nx  = 1'b0;
            state_nx = DATA;
          end
        end

        DATA: begin
          if (scl_rise) begin
            shift_nx = {shift_q[6:0], bus.sda_filtered};
            if (count_q != 4'd8) count_nx = count_q + 4'd1;
            // The 8th bit is still in flight on sda_filtered, so it is
            // merged here rather than read back from the shift register.
            if (count_q == 4'd7) begin
              rx_byte_nx = {shift_q[6:0], bus.sda_filtered};
              valid_nx   = 1'b1;
            end
          end else if (scl_fall && count_q == 4'd8) begin
            pull_nx  = 1'b1;
            count_nx = 4'd0;
            state_nx = DATA_ACK;
          end
        end

        DATA_ACK: begin
          if (scl_fall) begin
            pull_nx  = 1'b0;
            state_nx = DATA;
          end
        end

        IGNORE: begin
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      shift_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      pull_q    <= 1'b0;
      valid_q   <= 1'b0;
      matched_q <= 1'b0;
      busy_q    <= 1'b0;
      sda_prev  <= 1'b1;
      scl_prev  <= 1'b1;
    end else begin
      state_q   <= state_nx;
      count_q   <= count_nx;
      shift_q   <= shift_nx;
      rx_byte_q <= rx_byte_nx;
      pull_q    <= pull_nx;
      valid_q   <= valid_nx;
      matched_q <= matched_nx;
      busy_q    <= busy_nx;
      sda_prev  <= bus.sda_filtered;
      scl_prev  <= bus.scl_filtered;
    end
  end

  assign bus.sda_pull_low    = pull_q;
  assign bus.received_byte   = rx_byte_q;
  assign bus.byte_valid      = valid_q;
  assign bus.address_matched = matched_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_i2c_slave_write_receiver.sv
// Directed bench for the I2C write receiver; models the bus as a wired-AND of master drive and slave pull-low.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_slave_write_receiver;

  logic clk;
  logic rst_n;
  logic sda_drv;
  logic scl_drv;

  i2c_slave_write_receiver_if bus_if();

  assign bus_if.sda_filtered = sda_drv & ~bus_if.sda_pull_low;
  assign bus_if.scl_filtered = scl_drv;

  i2c_slave_write_receiver #(.SLAVE_ADDRESS(7'h50)) dut (
    .control_clock   (clk),
    .control_reset_n (rst_n),
    .bus             (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int         pull_seen = 0;
  int         glitch    = 0;
  logic       prev_scl  = 1'b1;
  logic       prev_pull = 1'b0;

  // Collect delivered bytes and watch that SDA drive never moves while SCL is high.
  always @(negedge clk) begin
    if (bus_if.byte_valid === 1'b1) rx_q.push_back(bus_if.received_byte);
    if (bus_if.sda_pull_low === 1'b1) pull_seen++;
    if (scl_drv && prev_scl && (bus_if.sda_pull_low !== prev_pull)) glitch++;
    prev_scl  = scl_drv;
    prev_pull = bus_if.sda_pull_low;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hDEAD;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_cond();
    sda_drv = 1'b1; idle(2);
    scl_drv = 1'b1; idle(2);
    sda_drv = 1'b0; idle(3);
    scl_drv = 1'b0; idle(2);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; idle(2);
    scl_drv = 1'b1; idle(2);
    sda_drv = 1'b1; idle(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i]; idle(2);
      scl_drv = 1'b1; idle(4);
      scl_drv = 1'b0; idle(2);
    end
  endtask

  // Eight data bits plus the ninth (ACK) clock; reports the ACK seen mid-high.
  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    sda_drv = 1'b1; idle(2);
    scl_drv = 1'b1; idle(2);
    acked = bus_if.sda_pull_low;
    idle(2);
    scl_drv = 1'b0; idle(2);
  endtask

  logic ack;

  initial begin
    rst_n   = 1'b0;
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    idle(3);

    // Reset state
    check("rst_pull",    bus_if.sda_pull_low,    0);
    check("rst_byte",    bus_if.received_byte,   0);
    check("rst_valid",   bus_if.byte_valid,      0);
    check("rst_matched", bus_if.address_matched, 0);
    check("rst_busy",    bus_if.busy,            0);
    rst_n = 1'b1;
    idle(3);

    // Address 0x50 write, data 0x3C, STOP
    rx_q.delete();
    start_cond();
    check("t1_busy", bus_if.busy, 1);
    check("t1_matched_pre", bus_if.address_matched, 0);
    send_byte(8'hA0, ack);
    check("t1_addr_ack", ack, 1);
    check("t1_matched", bus_if.address_matched, 1);
    send_byte(8'h3C, ack);
    check("t1_data_ack", ack, 1);
    check("t1_cnt", rx_q.size(), 1);
    check("t1_byte", q_at(0), 8'h3C);
    check("t1_hold", bus_if.received_byte, 8'h3C);
    stop_cond();
    check("t1_busy_stop", bus_if.busy, 0);
    check("t1_matched_stop", bus_if.address_matched, 0);
    check("t1_pull_stop", bus_if.sda_pull_low, 0);

    // Address 0x51 write: no ACK at all
    rx_q.delete(); pull_seen = 0;
    start_cond();
    send_byte(8'hA2, ack);
    check("t2_addr_nack", ack, 0);
    check("t2_matched", bus_if.address_matched, 0);
    send_byte(8'hFF, ack);
    check("t2_data_nack", ack, 0);
    stop_cond();
    check("t2_pull_seen", pull_seen, 0);
    check("t2_cnt", rx_q.size(), 0);

    // Address 0x50 read: NACK, ignored until STOP
    rx_q.delete(); pull_seen = 0;
    start_cond();
    send_byte(8'hA1, ack);
    check("t3_addr_nack", ack, 0);
    send_byte(8'h55, ack);
    check("t3_data_nack", ack, 0);
    check("t3_busy", bus_if.busy, 1);
    stop_cond();
    check("t3_cnt", rx_q.size(), 0);
    check("t3_pull_seen", pull_seen, 0);
    check("t3_busy_stop", bus_if.busy, 0);

    // Multi-byte with repeated START
    rx_q.delete();
    start_cond();
    send_byte(8'hA0, ack);  check("t4_a1_ack", ack, 1);
    send_byte(8'h11, ack);  check("t4_d1_ack", ack, 1);
    send_byte(8'h22, ack);  check("t4_d2_ack", ack, 1);
    check("t4_matched_1", bus_if.address_matched, 1);
    start_cond();
    check("t4_matched_rs", bus_if.address_matched, 0);
    check("t4_busy_rs", bus_if.busy, 1);
    send_byte(8'hA0, ack);  check("t4_a2_ack", ack, 1);
    check("t4_matched_2", bus_if.address_matched, 1);
    send_byte(8'h33, ack);  check("t4_d3_ack", ack, 1);
    stop_cond();
    check("t4_cnt", rx_q.size(), 3);
    check("t4_b0", q_at(0), 8'h11);
    check("t4_b1", q_at(1), 8'h22);
    check("t4_b2", q_at(2), 8'h33);

    // STOP after 4 bits of a data byte
    rx_q.delete();
    start_cond();
    send_byte(8'hA0, ack);
    send_byte(8'h5A, ack);
    check("t5_first", q_at(0), 8'h5A);
    send_bits(8'hC3, 4);
    stop_cond();
    check("t5_cnt", rx_q.size(), 1);
    check("t5_hold", bus_if.received_byte, 8'h5A);
    check("t5_pull", bus_if.sda_pull_low, 0);
    check("t5_busy", bus_if.busy, 0);

    // Asynchronous reset while acknowledging the address
    rx_q.delete();
    start_cond();
    send_bits(8'hA0, 8);
    idle(1);
    check("t6_pull_pre", bus_if.sda_pull_low, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pull_rst", bus_if.sda_pull_low, 0);
    check("t6_busy_rst", bus_if.busy, 0);
    check("t6_matched_rst", bus_if.address_matched, 0);
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    pull_seen = 0;
    scl_drv = 1'b0; idle(2);
    send_byte(8'h3C, ack);
    scl_drv = 1'b1; idle(2);
    check("t6_idle_ack", ack, 0);
    check("t6_idle_busy", bus_if.busy, 0);
    check("t6_idle_cnt", rx_q.size(), 0);
    check("t6_idle_pull", pull_seen, 0);
    start_cond();
    send_byte(8'hA0, ack);  check("t6_re_ack", ack, 1);
    send_byte(8'h77, ack);
    stop_cond();
    check("t6_re_cnt", rx_q.size(), 1);
    check("t6_re_byte", q_at(0), 8'h77);

    check("sda_stable_scl_high", glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
